// File: rtl/nibble_serial_adder_if.sv
// Handshake bundle for the nibble-serial adder: operand side, result side and busy status.
// The master modport is the source/consumer; slave is the adder itself.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial adder: one shared 4-bit full adder processes one operand nibble per clock,
// carrying the ripple carry in a register between nibbles.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    nibble_serial_adder_if.slave bus_io
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CntW    = $clog2(NIBBLES) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_sh_q, sum_q;
    logic [WIDTH-1:0] a_sh_d, b_sh_d, sum_sh_d;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q, cout_q, out_valid_q, busy_q;
    logic [4:0]       nib_sum;

    // The shared 4-bit full adder and the shift-register next values.
    always_comb begin
        nib_sum  = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + {4'b0, carry_q};
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        // New sum nibble enters at the top; after NIBBLES shifts it lines up LSB-first.
        sum_sh_d = (sum_sh_q >> 4) | (WIDTH'(nib_sum[3:0]) << (WIDTH - 4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        a_sh_q   <= bus_io.a;
                        b_sh_q   <= bus_io.b;
                        carry_q  <= bus_io.cin;
                        cnt_q    <= '0;
                        sum_sh_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    a_sh_q   <= a_sh_d;
                    b_sh_q   <= b_sh_d;
                    sum_sh_q <= sum_sh_d;
                    carry_q  <= nib_sum[4];
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        sum_q       <= sum_sh_d;
                        cout_q      <= nib_sum[4];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle);
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.sum       = sum_q;
    assign bus_io.cout      = cout_q;
    assign bus_io.busy      = busy_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboarded bench: the driver pushes {cout,sum} = a+b+cin on each accept, the monitor
// pops on each output handshake; directed cases plus randomized traffic with stalls.
module tb_nibble_serial_adder;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_accept = 0;
    int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
    logic [W:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // out_ready changes just after the rising edge so it is stable at the falling edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: a handshake seen at the falling edge completes on the next rising edge.
    logic       prev_hs = 1'b0;
    logic       hold_v = 1'b0;
    logic [W:0] held = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hs = 1'b0;
            hold_v  = 1'b0;
        end else begin
            if (prev_hs) check("out_valid_one_shot", bus.out_valid, 1'b0);
            if (hold_v && bus.out_valid) check("hold_stable", {bus.cout, bus.sum}, held);
            prev_hs = bus.out_valid && bus.out_ready;
            hold_v  = bus.out_valid && !bus.out_ready;
            held    = {bus.cout, bus.sum};
            if (bus.out_valid && bus.out_ready) begin
                check("result_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("result", {bus.cout, bus.sum}, exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int  waited = 0;
        bit  done = 0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
                last_accept = cyc + 1;
                done = 1;
            end else if (++waited > 50) begin
                check("accept_timeout", bus.in_ready, 1'b1);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.in_ready) break;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    int lat;
    int acc1;

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_sum", {bus.cout, bus.sum}, '0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic add and latency
        send(16'h1234, 16'h1111, 1'b0);
        check("busy_after_accept", bus.busy, 1'b1);
        wait_valid(lat);
        check("latency", lat, 4);
        check("t1_sum", {bus.cout, bus.sum}, 17'h02345);
        drain();

        // 2: carry ripples through every nibble
        @(posedge clk); #1;
        send(16'hFFFF, 16'h0000, 1'b1);
        wait_valid(lat);
        check("t2_sum", {bus.cout, bus.sum}, 17'h10000);
        drain();

        // 3: result held under back-pressure; in_valid ignored meanwhile
        ready_mode = 0;
        @(posedge clk); #1;
        send(16'h8000, 16'h8000, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.a = 16'hDEAD;
            bus.b = 16'hBEEF;
            @(negedge clk);
            check("t3_valid_held", bus.out_valid, 1'b1);
            check("t3_in_ready", bus.in_ready, 1'b0);
            check("t3_sum", {bus.cout, bus.sum}, 17'h10000);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        ready_mode = 1;
        drain();
        check("t3_busy_clear", bus.busy, 1'b0);

        // 4: reset mid-RUN aborts the operation
        @(posedge clk); #1;
        send(16'h5555, 16'h3333, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t4_out_valid", bus.out_valid, 1'b0);
        check("t4_busy", bus.busy, 1'b0);
        check("t4_sum", {bus.cout, bus.sum}, '0);
        check("t4_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_no_spurious", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        send(16'h0001, 16'h0001, 1'b0);
        wait_valid(lat);
        check("t4_next_sum", {bus.cout, bus.sum}, 17'h00002);
        drain();

        // 5: back-to-back issue rate
        @(posedge clk); #1;
        send(16'hA5A5, 16'h5A5A, 1'b0);
        acc1 = last_accept;
        send(16'h0F0F, 16'h0101, 1'b1);
        check("t5_issue_period", last_accept - acc1, 6);
        drain();

        // 6: randomized traffic with random stalls and corner operands
        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 17 == 0) ra = '1;
            if (n % 23 == 0) rb = '1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send(ra, rb, 1'($urandom_range(0, 1)));
        end
        ready_mode = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
